// File: rtl/eth_phy_10g_link_ctrl.sv
// Link bring-up, supervision and PRBS31 loopback test sequencer for the 10GBASE-R PHY.
// Runs in the PHY rx_clk domain and drives the PHY cfg_* and SERDES receiver reset.
module eth_phy_10g_link_ctrl #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT   = 1024,
  parameter int unsigned STATUS_TIMEOUT = 4096,
  parameter int unsigned MAX_RETRY      = 7,
  parameter int unsigned PRBS_SETTLE    = 4,
  parameter int unsigned PRBS_LEN_WIDTH = 16,
  parameter int unsigned ERR_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_block_lock,
  input  logic                      rx_status,
  input  logic                      rx_high_ber,
  input  logic [6:0]                rx_error_count,
  input  logic                      serdes_rx_reset_req,
  input  logic                      restart,
  input  logic                      prbs_start,
  input  logic [PRBS_LEN_WIDTH-1:0] prbs_len,
  output logic                      serdes_rst,
  output logic                      cfg_tx_prbs31_enable,
  output logic                      cfg_rx_prbs31_enable,
  output logic                      link_up,
  output logic                      fault,
  output logic [3:0]                retry_count,
  output logic                      prbs_busy,
  output logic                      prbs_done,
  output logic                      prbs_pass,
  output logic [ERR_WIDTH-1:0]      prbs_err_total,
  output logic                      high_ber_seen,
  output logic [2:0]                state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_LOCK   = 3'd1,
    S_STATUS = 3'd2,
    S_UP     = 3'd3,
    S_PRBS   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int unsigned MAX_A   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B   = (MAX_A > STATUS_TIMEOUT) ? MAX_A : STATUS_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_B > PRBS_SETTLE + 1) ? MAX_B : PRBS_SETTLE + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAT_LAST = CNT_W'(STATUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(PRBS_SETTLE);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [3:0]                retry_q, retry_d;
  logic [PRBS_LEN_WIDTH-1:0] rem_q, rem_d;
  logic [ERR_WIDTH-1:0]      err_q, err_d;
  logic                      pass_q, pass_d;
  logic                      done_q, done_d;
  logic                      hb_q, hb_d;
  logic                      srst_q, en_q, link_q, fault_q, busy_q;

  logic                      reenter;
  logic                      take_retry;
  logic [3:0]                retry_inc;
  logic [ERR_WIDTH:0]        err_sum;
  logic [ERR_WIDTH-1:0]      err_sat;

  always_comb begin
    err_sum   = {1'b0, err_q} + (ERR_WIDTH + 1)'(rx_error_count);
    err_sat   = err_sum[ERR_WIDTH] ? '1 : err_sum[ERR_WIDTH-1:0];
    retry_inc = retry_q + 4'd1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    retry_d    = retry_q;
    rem_d      = rem_q;
    err_d      = err_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    hb_d       = hb_q | ((state_q == S_UP) && rx_high_ber);
    reenter    = 1'b0;
    take_retry = 1'b0;

    if (serdes_rx_reset_req && (state_q != S_FAULT)) begin
      state_d = S_RESET;
      reenter = 1'b1;
    end else if (restart) begin
      state_d = S_RESET;
      reenter = 1'b1;
      retry_d = '0;
      hb_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_RESET: if (cnt_q == RST_LAST) state_d = S_LOCK;
        S_LOCK: begin
          if (rx_block_lock)           state_d    = S_STATUS;
          else if (cnt_q == LOCK_LAST) take_retry = 1'b1;
        end
        S_STATUS: begin
          if (rx_status) begin
            state_d = S_UP;
            retry_d = '0;
          end else if (!rx_block_lock) begin
            state_d = S_LOCK;
          end else if (cnt_q == STAT_LAST) begin
            take_retry = 1'b1;
          end
        end
        S_UP: begin
          if (!rx_block_lock)  state_d = S_LOCK;
          else if (!rx_status) state_d = S_STATUS;
          else if (prbs_start && (prbs_len != '0)) begin
            state_d = S_PRBS;
            rem_d   = prbs_len;
            err_d   = '0;
            pass_d  = 1'b0;
          end
        end
        S_PRBS: begin
          // Counter freezes once settle has elapsed so long tests cannot wrap it.
          if (cnt_q >= SETTLE_C) begin
            cnt_d = cnt_q;
            if (!rx_block_lock) begin
              state_d = S_LOCK;
              done_d  = 1'b1;
              pass_d  = 1'b0;
            end else begin
              err_d = err_sat;
              rem_d = rem_q - PRBS_LEN_WIDTH'(1);
              if (rem_q == PRBS_LEN_WIDTH'(1)) begin
                state_d = S_STATUS;
                done_d  = 1'b1;
                pass_d  = (err_sat == '0);
              end
            end
          end
        end
        S_FAULT: ;
        default: state_d = S_RESET;
      endcase
    end

    if (take_retry) begin
      retry_d = retry_inc;
      state_d = (retry_inc == 4'(MAX_RETRY)) ? S_FAULT : S_RESET;
    end

    if (reenter && (state_q == S_PRBS)) begin
      done_d = 1'b1;
      pass_d = 1'b0;
    end

    if (reenter || (state_d != state_q)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      retry_q <= '0;
      rem_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      hb_q    <= 1'b0;
      srst_q  <= 1'b1;
      en_q    <= 1'b0;
      link_q  <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      hb_q    <= hb_d;
      srst_q  <= (state_d == S_RESET);
      en_q    <= (state_d == S_PRBS);
      link_q  <= (state_d == S_UP);
      fault_q <= (state_d == S_FAULT);
      busy_q  <= (state_d == S_PRBS);
    end
  end

  assign serdes_rst           = srst_q;
  assign cfg_tx_prbs31_enable = en_q;
  assign cfg_rx_prbs31_enable = en_q;
  assign link_up              = link_q;
  assign fault                = fault_q;
  assign retry_count          = retry_q;
  assign prbs_busy            = busy_q;
  assign prbs_done            = done_q;
  assign prbs_pass            = pass_q;
  assign prbs_err_total       = err_q;
  assign high_ber_seen        = hb_q;
  assign state                = state_q;

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Bench for eth_phy_10g_link_ctrl: cycle-indexed vector tables for bring-up/retry,
// hand sequences for link supervision, and a result scoreboard for PRBS tests.
module tb_eth_phy_10g_link_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_block_lock, rx_status, rx_high_ber;
  logic [6:0]  rx_error_count;
  logic        serdes_rx_reset_req, restart, prbs_start;
  logic [15:0] prbs_len;
  logic        serdes_rst, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable;
  logic        link_up, fault, prbs_busy, prbs_done, prbs_pass, high_ber_seen;
  logic [3:0]  retry_count;
  logic [15:0] prbs_err_total;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  eth_phy_10g_link_ctrl #(
    .RESET_CYCLES  (16),
    .LOCK_TIMEOUT  (1024),
    .STATUS_TIMEOUT(4096),
    .MAX_RETRY     (7),
    .PRBS_SETTLE   (4),
    .PRBS_LEN_WIDTH(16),
    .ERR_WIDTH     (16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_block_lock       (rx_block_lock),
    .rx_status           (rx_status),
    .rx_high_ber         (rx_high_ber),
    .rx_error_count      (rx_error_count),
    .serdes_rx_reset_req (serdes_rx_reset_req),
    .restart             (restart),
    .prbs_start          (prbs_start),
    .prbs_len            (prbs_len),
    .serdes_rst          (serdes_rst),
    .cfg_tx_prbs31_enable(cfg_tx_prbs31_enable),
    .cfg_rx_prbs31_enable(cfg_rx_prbs31_enable),
    .link_up             (link_up),
    .fault               (fault),
    .retry_count         (retry_count),
    .prbs_busy           (prbs_busy),
    .prbs_done           (prbs_done),
    .prbs_pass           (prbs_pass),
    .prbs_err_total      (prbs_err_total),
    .high_ber_seen       (high_ber_seen),
    .state               (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pass;
    logic [15:0] tot;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];

  // Monitor: every prbs_done pulse deposits the reported result.
  always @(negedge clk) begin
    if (prbs_done) obs_q.push_back(res_t'{prbs_pass, prbs_err_total});
  end

  typedef struct {
    int         rel;
    logic       lock;
    logic       status;
    logic       rstrt;
    logic [2:0] st;
    logic       srst;
    logic       link;
    logic       flt;
    logic       hb;
    logic [3:0] rty;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input int rel, input logic lock, input logic status, input logic rstrt,
                      input int st, input logic srst, input logic link, input logic flt,
                      input logic hb, input int rty);
    vec_t v;
    v.rel = rel; v.lock = lock; v.status = status; v.rstrt = rstrt;
    v.st = 3'(st); v.srst = srst; v.link = link; v.flt = flt; v.hb = hb; v.rty = 4'(rty);
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_tbl(input string nm, input int lo, input int hi);
    int cyc = 0;
    for (int i = lo; i < hi; i++) begin
      while (cyc < tbl[i].rel) begin
        step();
        cyc++;
      end
      check($sformatf("%s[%0d].state", nm, cyc), state, tbl[i].st);
      check($sformatf("%s[%0d].serdes_rst", nm, cyc), serdes_rst, tbl[i].srst);
      check($sformatf("%s[%0d].link_up", nm, cyc), link_up, tbl[i].link);
      check($sformatf("%s[%0d].fault", nm, cyc), fault, tbl[i].flt);
      check($sformatf("%s[%0d].high_ber_seen", nm, cyc), high_ber_seen, tbl[i].hb);
      check($sformatf("%s[%0d].retry", nm, cyc), retry_count, tbl[i].rty);
      rx_block_lock = tbl[i].lock;
      rx_status     = tbl[i].status;
      restart       = tbl[i].rstrt;
    end
  endtask

  task automatic wait_up(input string nm);
    int n = 0;
    while (state != 3'd3 && n < 64) begin
      step();
      n++;
    end
    check({nm, "_back_up"}, state, 3'd3);
  endtask

  task automatic run_prbs(input string nm, input int len, input logic [6:0] e_settle,
                          input logic [6:0] e_run, input int n_run, input int drop_at,
                          input logic exp_pass, input int exp_total, input int exp_en,
                          input int exp_state);
    int   en_cnt = 0;
    bit   seen   = 0;
    res_t got, want;
    exp_q.push_back(res_t'{exp_pass, 16'(exp_total)});
    prbs_len   = 16'(len);
    prbs_start = 1'b1;
    step();
    prbs_start = 1'b0;
    check({nm, "_busy"}, prbs_busy, 1'b1);
    for (int k = 1; k <= len + 24; k++) begin
      if (cfg_tx_prbs31_enable) en_cnt++;
      if (prbs_done) begin
        seen = 1;
        break;
      end
      rx_error_count = (k <= 4) ? e_settle : ((k - 5 < n_run) ? e_run : 7'd0);
      if (k == drop_at) rx_block_lock = 1'b0;
      step();
    end
    rx_error_count = '0;
    check({nm, "_done_seen"}, seen, 1'b1);
    check({nm, "_state_after"}, state, 3'(exp_state));
    check({nm, "_rx_en_low"}, cfg_rx_prbs31_enable, 1'b0);
    check({nm, "_busy_low"}, prbs_busy, 1'b0);
    check({nm, "_en_cycles"}, en_cnt, exp_en);
    step();
    check({nm, "_done_one_cycle"}, prbs_done, 1'b0);
    check({nm, "_result_count"}, obs_q.size(), 1);
    want = exp_q.pop_front();
    if (obs_q.size() != 0) begin
      got = obs_q.pop_front();
      check({nm, "_pass"}, got.pass, want.pass);
      check({nm, "_err_total"}, got.tot, want.tot);
    end
    obs_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat;
    rst = 1'b1; rx_block_lock = 1'b0; rx_status = 1'b0; rx_high_ber = 1'b0;
    rx_error_count = '0; serdes_rx_reset_req = 1'b0; restart = 1'b0;
    prbs_start = 1'b0; prbs_len = '0;

    // Bring-up: lock at 30, status at 60.
    addv(0,  0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(15, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(16, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    addv(30, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    addv(31, 1, 0, 0, 2, 0, 0, 0, 0, 0);
    addv(60, 1, 1, 0, 2, 0, 0, 0, 0, 0);
    addv(61, 1, 1, 0, 3, 0, 1, 0, 0, 0);
    // Lock never arrives: 7 attempts of 16+1024 cycles, then fault and restart.
    addv(0,    0, 0, 0, 0, 1, 0, 0, 1, 0);
    addv(15,   0, 0, 0, 0, 1, 0, 0, 1, 0);
    addv(16,   0, 0, 0, 1, 0, 0, 0, 1, 0);
    addv(1039, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    addv(1040, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    addv(7279, 0, 0, 0, 1, 0, 0, 0, 1, 6);
    addv(7280, 0, 0, 0, 5, 0, 0, 1, 1, 7);
    addv(7290, 0, 0, 1, 5, 0, 0, 1, 1, 7);
    addv(7291, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    step(3);
    check("rst_state", state, 3'd0);
    check("rst_serdes_rst", serdes_rst, 1'b1);
    check("rst_en", cfg_tx_prbs31_enable, 1'b0);
    check("rst_pass_total", {prbs_pass, prbs_done, prbs_busy, prbs_err_total}, '0);
    rst = 1'b0;

    run_tbl("bringup", 0, 7);

    // Status blips low; a prbs_start while in S_STATUS must be dropped.
    rx_status = 1'b0;
    step();
    check("blip_state", state, 3'd2);
    check("blip_link_up", link_up, 1'b0);
    rx_status = 1'b1; prbs_start = 1'b1; prbs_len = 16'd100;
    step();
    prbs_start = 1'b0;
    check("blip_recover", state, 3'd3);
    step();
    check("start_not_queued", state, 3'd3);

    check("hb_clear", high_ber_seen, 1'b0);
    rx_high_ber = 1'b1;
    step();
    rx_high_ber = 1'b0;
    check("hb_set", high_ber_seen, 1'b1);
    step(5);
    check("hb_sticky", high_ber_seen, 1'b1);

    prbs_start = 1'b1; prbs_len = '0;
    step();
    prbs_start = 1'b0;
    check("len0_ignored", state, 3'd3);
    check("len0_no_en", cfg_tx_prbs31_enable, 1'b0);

    run_prbs("prbs_clean", 100, 7'd7, 7'd0, 0, -1, 1'b1, 0, 104, 2);
    wait_up("prbs_clean");
    run_prbs("prbs_err", 100, 7'd7, 7'd3, 10, -1, 1'b0, 30, 104, 2);
    wait_up("prbs_err");
    sat = 66 * 1000;
    if (sat > 65535) sat = 65535;
    run_prbs("prbs_sat", 1000, 7'd66, 7'd66, 1000, -1, 1'b0, sat, 1004, 2);
    wait_up("prbs_sat");
    run_prbs("prbs_abort", 100, 7'd0, 7'd0, 0, 20, 1'b0, 0, 20, 1);
    rx_block_lock = 1'b1;
    wait_up("prbs_abort");

    // SERDES reset request outranks restart: sticky flag and retry survive.
    serdes_rx_reset_req = 1'b1; restart = 1'b1; rx_block_lock = 1'b0; rx_status = 1'b0;
    step();
    serdes_rx_reset_req = 1'b0; restart = 1'b0;
    check("req_state", state, 3'd0);
    check("req_serdes_rst", serdes_rst, 1'b1);
    check("req_hb_kept", high_ber_seen, 1'b1);
    check("req_retry", retry_count, 4'd0);

    run_tbl("retry", 7, 16);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
